// File: rtl/leiwand_rv32_wb_byte_master.sv
// leiwand_rv32_wb_byte_master
// Turns one CPU load/store (byte, halfword or word) into a sequence of
// single-byte Wishbone transfers. Bytes are handled little-endian. Loads
// are zero- or sign-extended.
// Optional feature: define LEIWAND_BUS_TIMEOUT_EN to enable a per-byte bus
// timeout. When it fires, the access is abandoned and completes with o_err=1
// and o_rdata=0. Without it, the master waits forever and o_err is tied low.
module leiwand_rv32_wb_byte_master #(
  parameter int ADDR_W         = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_wdata,
  input  logic              i_we,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  output logic [31:0]       o_rdata,
  output logic              o_done,
  output logic              o_busy,
  output logic              o_err,
  output logic              o_cyc,
  output logic              o_stb,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_adr,
  output logic [7:0]        o_dat,
  input  logic [7:0]        i_dat,
  input  logic              i_ack,
  input  logic              i_stall
);

  typedef enum logic [2:0] {IDLE, ISSUE, STB, WAIT, DONE} state_t;

  state_t            state_q;
  state_t            state_d;

  // Request captured at acceptance; stable for the whole access
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;

  logic [1:0]        k_q;
  logic [1:0]        k_last;
  logic              last_byte;
  logic              accept;
  logic              byte_acked;
  logic              tmo_hit;

  logic [31:0]       rbuf_q;
  logic [31:0]       bytes_now;
  logic [31:0]       rdata_q;

  logic              cyc;
  logic              stb;
  logic              done;
  logic              busy;

  // The address bits above ADDR_W are intentionally ignored
  logic              unused_addr_bits;
  assign unused_addr_bits = ^i_addr[31:ADDR_W];

  // Extend the assembled little-endian bytes to 32 bits for the given width
  function automatic logic [31:0] load_extend(input logic [31:0] b,
                                              input logic [1:0]  sz,
                                              input logic        uns);
    logic signed [7:0]  b8;
    logic signed [15:0] h16;
    b8  = b[7:0];
    h16 = b[15:0];
    case (sz)
      2'd0:    load_extend = uns ? {24'd0, b[7:0]}  : 32'(b8);
      2'd1:    load_extend = uns ? {16'd0, b[15:0]} : 32'(h16);
      default: load_extend = b;
    endcase
  endfunction

  // Byte count minus one: 1, 2 or 4 bytes (size 3 behaves as a word)
  function automatic logic [1:0] last_index(input logic [1:0] sz);
    case (sz)
      2'd0:    last_index = 2'd0;
      2'd1:    last_index = 2'd1;
      default: last_index = 2'd3;
    endcase
  endfunction

  assign accept     = (state_q == IDLE) && i_req;
  assign k_last     = last_index(size_q);
  assign last_byte  = (k_q == k_last);
  assign byte_acked = (state_q == WAIT) && i_ack;

`ifdef LEIWAND_BUS_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt_q;
  logic          err_q;

  // Cycles spent in the current ISSUE/WAIT visit. The count restarts whenever the state changes.
  always_ff @(posedge i_clk) begin
    if (i_rst || (state_d != state_q) ||
        !((state_q == ISSUE) || (state_q == WAIT))) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  assign tmo_hit = ((state_q == ISSUE) || (state_q == WAIT)) &&
                   (tmo_cnt_q == TMO_LAST);

  // Error flag lives only for the DONE cycle of a timed-out access
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (state_d == DONE) && tmo_hit && !byte_acked;
    end
  end

  assign o_err = err_q;
`else
  logic [$clog2(TIMEOUT_CYCLES + 1)-1:0] unused_tmo;
  assign unused_tmo = '0;
  assign tmo_hit    = 1'b0;
  assign o_err      = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and bus control decode; a completed handshake wins over a timeout
  always_comb begin
    state_d = state_q;
    cyc     = 1'b0;
    stb     = 1'b0;
    done    = 1'b0;
    busy    = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (i_req) state_d = ISSUE;
      end
      ISSUE: begin
        cyc = 1'b1;
        if (!i_stall)     state_d = STB;
        else if (tmo_hit) state_d = DONE;
      end
      STB: begin
        cyc     = 1'b1;
        stb     = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        cyc = 1'b1;
        if (i_ack)        state_d = last_byte ? DONE : ISSUE;
        else if (tmo_hit) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Latch the request when it is accepted
  always_ff @(posedge i_clk) begin
    if (accept) begin
      addr_q  <= i_addr[ADDR_W-1:0];
      wdata_q <= i_wdata;
      we_q    <= i_we;
      size_q  <= i_size;
      uns_q   <= i_unsigned;
    end
  end

  // Byte counter: cleared on acceptance, advanced on each acked non-final byte
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      k_q <= 2'd0;
    end else if (accept) begin
      k_q <= 2'd0;
    end else if (byte_acked && !last_byte) begin
      k_q <= k_q + 2'd1;
    end
  end

  // Read bytes collected so far, with the byte arriving this cycle merged in
  always_comb begin
    bytes_now            = rbuf_q;
    bytes_now[8*k_q +: 8] = i_dat;
  end

  // Store each returned load byte at its little-endian position
  always_ff @(posedge i_clk) begin
    if (byte_acked && !we_q) begin
      rbuf_q <= bytes_now;
    end
  end

  // Load result updates on the edge that enters DONE. A timeout forces it to zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rdata_q <= '0;
    end else if (byte_acked && last_byte && !we_q) begin
      rdata_q <= load_extend(bytes_now, size_q, uns_q);
    end else if (tmo_hit && (state_d == DONE)) begin
      rdata_q <= '0;
    end
  end

  assign o_rdata = rdata_q;
  assign o_done  = done;
  assign o_busy  = busy;
  assign o_cyc   = cyc;
  assign o_stb   = stb;
  assign o_we    = cyc & we_q;
  assign o_adr   = cyc ? (addr_q + ADDR_W'(k_q)) : '0;
  assign o_dat   = (cyc && we_q) ? wdata_q[8*k_q +: 8] : 8'd0;

endmodule

// File: tb/tb_leiwand_rv32_wb_byte_master.sv
// Testbench for leiwand_rv32_wb_byte_master. A byte-wide RAM slave asserts stall
// while stb is high and acks a programmable number of cycles after stb.
module tb_leiwand_rv32_wb_byte_master;

  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req;
  logic [31:0]       i_addr;
  logic [31:0]       i_wdata;
  logic              i_we;
  logic [1:0]        i_size;
  logic              i_unsigned;
  logic [31:0]       o_rdata;
  logic              o_done;
  logic              o_busy;
  logic              o_err;
  logic              o_cyc;
  logic              o_stb;
  logic              o_we;
  logic [ADDR_W-1:0] o_adr;
  logic [7:0]        o_dat;
  logic [7:0]        rd_q;
  logic              ack = 1'b0;
  logic              stall_w;
  logic              force_stall;

  always #5 clk = ~clk;

  leiwand_rv32_wb_byte_master #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(i_req), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_we(i_we), .i_size(i_size), .i_unsigned(i_unsigned), .o_rdata(o_rdata),
    .o_done(o_done), .o_busy(o_busy), .o_err(o_err), .o_cyc(o_cyc), .o_stb(o_stb),
    .o_we(o_we), .o_adr(o_adr), .o_dat(o_dat), .i_dat(rd_q), .i_ack(ack),
    .i_stall(stall_w)
  );

  assign stall_w = o_stb | force_stall;

  // Slave model
  logic [7:0]        ram [32];
  logic [ADDR_W-1:0] adr_log [1024];
  int                n_log = 0;
  int                pend = 0;
  int                ack_dly;

  always @(posedge clk) begin
    ack <= 1'b0;
    if (pend > 0) begin
      pend <= pend - 1;
      if (pend == 1) ack <= 1'b1;
    end
    if (o_cyc && o_stb) begin
      adr_log[n_log] <= o_adr;
      n_log <= n_log + 1;
      if (o_we) ram[o_adr] <= o_dat;
      else      rd_q <= ram[o_adr];
      if (ack_dly == 1)     ack <= 1'b1;
      else if (ack_dly > 1) pend <= ack_dly - 1;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Results of the last access
  int          r_done_cyc;
  int          r_ndone;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_busy_done;
  logic        r_busy_c1;
  logic        r_post_ok;

  task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic we,
                        input logic [1:0] sz, input logic un, input int stall_n,
                        input int pulse_at, input int window, input bit full);
    @(negedge clk);
    i_addr = a; i_wdata = wd; i_we = we; i_size = sz; i_unsigned = un;
    i_req = 1'b1; force_stall = 1'b0;
    r_done_cyc = -1; r_ndone = 0; r_rdata = 'x; r_err = 1'bx;
    r_busy_done = 1'b0; r_busy_c1 = 1'b0; r_post_ok = 1'b0;
    for (int c = 1; c <= window; c++) begin
      @(negedge clk);
      i_req = (c == pulse_at);
      if (c == pulse_at) begin
        i_addr = 32'h10; i_we = 1'b1; i_size = 2'd2;
      end
      if (c == 1) r_busy_c1 = o_busy;
      if (o_done) begin
        r_ndone++;
        if (r_done_cyc < 0) begin
          r_done_cyc = c; r_rdata = o_rdata; r_err = o_err; r_busy_done = o_busy;
        end
      end else if (r_done_cyc > 0 && c == r_done_cyc + 1) begin
        r_post_ok = !o_busy;
      end
      force_stall = (c <= stall_n);
      if (!full && r_done_cyc > 0 && c > r_done_cyc) break;
    end
    force_stall = 1'b0;
    i_req = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    int          dly;
    int          stall;
    logic [31:0] exp_rdata;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[11];
  int   log_base;

  initial begin
    vecs[0]  = '{32'h0000_0004, 32'hA1B2_C3D4, 1'b1, 2'd2, 1'b0, 2, 0, 32'h0000_0000, 17};
    vecs[1]  = '{32'h0000_0005, 32'h0,         1'b0, 2'd0, 1'b0, 2, 0, 32'hFFFF_FFC3, 5};
    vecs[2]  = '{32'h0000_0005, 32'h0,         1'b0, 2'd0, 1'b1, 2, 0, 32'h0000_00C3, 5};
    vecs[3]  = '{32'h0000_0004, 32'h0,         1'b0, 2'd1, 1'b0, 2, 0, 32'hFFFF_C3D4, 9};
    vecs[4]  = '{32'h0000_0006, 32'h0,         1'b0, 2'd1, 1'b1, 1, 0, 32'h0000_A1B2, 7};
    vecs[5]  = '{32'h0000_0004, 32'h0,         1'b0, 2'd2, 1'b0, 4, 0, 32'hA1B2_C3D4, 25};
    vecs[6]  = '{32'h0000_0008, 32'h1234_5655, 1'b1, 2'd0, 1'b0, 2, 3, 32'hA1B2_C3D4, 8};
    vecs[7]  = '{32'h0000_0005, 32'h0,         1'b0, 2'd3, 1'b0, 2, 0, 32'h55A1_B2C3, 17};
    vecs[8]  = '{32'hFFFF_FFFF, 32'h0000_7F80, 1'b1, 2'd1, 1'b0, 2, 0, 32'h55A1_B2C3, 9};
    vecs[9]  = '{32'h0000_001F, 32'h0,         1'b0, 2'd1, 1'b0, 2, 0, 32'h0000_7F80, 9};
    vecs[10] = '{32'h0000_001F, 32'h0,         1'b0, 2'd0, 1'b0, 3, 1, 32'hFFFF_FF80, 7};

    rst = 1'b1; i_req = 1'b0; i_addr = '0; i_wdata = '0; i_we = 1'b0;
    i_size = 2'd0; i_unsigned = 1'b0; force_stall = 1'b0; ack_dly = 2;
    log_base = 0;
    repeat (3) @(negedge clk);
    check("reset cyc",   32'(o_cyc),   32'd0);
    check("reset stb",   32'(o_stb),   32'd0);
    check("reset we",    32'(o_we),    32'd0);
    check("reset adr",   32'(o_adr),   32'd0);
    check("reset dat",   32'(o_dat),   32'd0);
    check("reset rdata", o_rdata,      32'd0);
    check("reset done",  32'(o_done),  32'd0);
    check("reset busy",  32'(o_busy),  32'd0);
    check("reset err",   32'(o_err),   32'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      ack_dly  = vecs[i].dly;
      log_base = n_log;
      access(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].size, vecs[i].uns,
             vecs[i].stall, -1, 80, 1'b0);
      check($sformatf("v%0d done cycle", i), 32'(r_done_cyc), 32'(vecs[i].exp_cyc));
      check($sformatf("v%0d rdata", i), r_rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d err", i), 32'(r_err), 32'd0);
      check($sformatf("v%0d busy at start", i), 32'(r_busy_c1), 32'd1);
      check($sformatf("v%0d busy at done", i), 32'(r_busy_done), 32'd1);
      check($sformatf("v%0d single pulse", i), 32'(r_post_ok), 32'd1);
      if (i == 0) begin
        check("ram[4]", 32'(ram[4]), 32'h0000_00D4);
        check("ram[5]", 32'(ram[5]), 32'h0000_00C3);
        check("ram[6]", 32'(ram[6]), 32'h0000_00B2);
        check("ram[7]", 32'(ram[7]), 32'h0000_00A1);
      end
      if (i == 9) begin
        check("wrap adr0", 32'(adr_log[log_base]),     32'd31);
        check("wrap adr1", 32'(adr_log[log_base + 1]), 32'd0);
        check("wrap bytes", 32'(n_log - log_base),     32'd2);
      end
    end

    // Request pulsed while busy with a word load is ignored
    ack_dly  = 2;
    log_base = n_log;
    access(32'h4, 32'h0, 1'b0, 2'd2, 1'b0, 0, 6, 40, 1'b1);
    check("busy req done count", 32'(r_ndone), 32'd1);
    check("busy req done cycle", 32'(r_done_cyc), 32'd17);
    check("busy req rdata", r_rdata, 32'hA1B2_C3D4);
    check("busy req bytes", 32'(n_log - log_base), 32'd4);

    // Reset during the WAIT of byte 2 of a word load
    begin
      int ndone;
      ndone = 0;
      @(negedge clk);
      i_addr = 32'h4; i_wdata = '0; i_we = 1'b0; i_size = 2'd2; i_unsigned = 1'b0;
      i_req = 1'b1;
      for (int c = 1; c <= 11; c++) begin
        @(negedge clk);
        i_req = 1'b0;
      end
      check("mid wait cyc", 32'(o_cyc), 32'd1);
      check("mid wait stb", 32'(o_stb), 32'd0);
      check("mid wait adr", 32'(o_adr), 32'd6);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("post rst cyc",   32'(o_cyc),  32'd0);
      check("post rst busy",  32'(o_busy), 32'd0);
      check("post rst done",  32'(o_done), 32'd0);
      check("post rst rdata", o_rdata,     32'd0);
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (o_done) ndone++;
      end
      check("post rst no done", 32'(ndone), 32'd0);
    end
    access(32'h5, 32'h0, 1'b0, 2'd0, 1'b1, 0, -1, 40, 1'b0);
    check("after rst done cycle", 32'(r_done_cyc), 32'd5);
    check("after rst rdata", r_rdata, 32'h0000_00C3);

`ifdef LEIWAND_BUS_TIMEOUT_EN
    // Slave never acks: completion 16 cycles after entering WAIT
    ack_dly = 0;
    access(32'h5, 32'h0, 1'b0, 2'd0, 1'b0, 0, -1, 60, 1'b0);
    check("timeout done cycle", 32'(r_done_cyc), 32'd19);
    check("timeout err", 32'(r_err), 32'd1);
    check("timeout rdata", r_rdata, 32'd0);
    check("timeout cyc dropped", 32'(o_cyc), 32'd0);
    ack_dly = 2;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
